// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock frequency meter and related measurement blocks.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meas_state_t;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_PER_W = 12;

  localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;
  localparam logic [DEF_PER_W-1:0] PER_SAT = '1;

endpackage

// File: rtl/clk_freq_meter_if.sv
// Control and result bundle of the clock frequency meter; the meter is the slave side.
interface clk_freq_meter_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 12
);

  logic             en;
  logic             sig_in;
  logic             rise_pulse;
  logic [CNT_W-1:0] edge_cnt;
  logic [PER_W-1:0] per_min;
  logic [PER_W-1:0] per_max;
  logic             meas_valid;
  logic             overflow;

  modport master (
    output en, sig_in,
    input  rise_pulse, edge_cnt, per_min, per_max, meas_valid, overflow
  );

  modport slave (
    input  en, sig_in,
    output rise_pulse, edge_cnt, per_min, per_max, meas_valid, overflow
  );

endinterface

// File: rtl/sync_edge_det.sv
// Synchroniser for an asynchronous level plus combinational edge detect on the synced value.
// Latency SYNC_STAGES clk to d_sync; rise/fall valid in the cycle d_sync changes; no backpressure.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic d_sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d_async};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign d_sync = chain[SYNC_STAGES-1];
  assign rise   = d_sync & ~prev;
  assign fall   = ~d_sync & prev;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of sig_in per GATE_CYCLES window and tracks min/max rise-to-rise period.
// rise_pulse SYNC_STAGES+1 clk after the input edge; results strobe once per window; no backpressure.
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PER_W       = DEF_PER_W
) (
  input logic             clk,
  input logic             rst_n,
  clk_freq_meter_if.slave bus
);

  localparam int              GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]   GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             rise_c;
  logic             d_sync;
  logic             fall;
  logic             sync_unused;

  meas_state_t      state;
  logic             rise_q;
  logic [GW-1:0]    gate;
  logic [PER_W-1:0] per_cnt;
  logic [CNT_W-1:0] acc_edges;
  logic [PER_W-1:0] acc_min;
  logic [PER_W-1:0] acc_max;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [PER_W-1:0] per_min_q;
  logic [PER_W-1:0] per_max_q;
  logic             meas_valid_q;
  logic             overflow_q;

  logic [PER_W-1:0] per_nxt;
  logic [CNT_W-1:0] edges_nxt;
  logic [PER_W-1:0] min_nxt;
  logic [PER_W-1:0] max_nxt;
  logic             edge_sat;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_async(bus.sig_in),
    .d_sync (d_sync),
    .rise   (rise_c),
    .fall   (fall)
  );

  assign sync_unused = d_sync ^ fall;

  // per_cnt holds cycles since the last rise minus one, so per_nxt is the period ending this cycle.
  always_comb begin
    per_nxt   = (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 1'b1;
    edge_sat  = rise_q && (acc_edges == CNT_MAX);
    edges_nxt = acc_edges;
    min_nxt   = acc_min;
    max_nxt   = acc_max;
    if (rise_q) begin
      edges_nxt = edge_sat ? CNT_MAX : acc_edges + 1'b1;
      if (per_nxt < acc_min) min_nxt = per_nxt;
      if (per_nxt > acc_max) max_nxt = per_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rise_q       <= 1'b0;
      gate         <= '0;
      per_cnt      <= '0;
      acc_edges    <= '0;
      acc_min      <= '0;
      acc_max      <= '0;
      edge_cnt_q   <= '0;
      per_min_q    <= '1;
      per_max_q    <= '0;
      meas_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rise_q       <= rise_c;
      meas_valid_q <= 1'b0;
      if (!bus.en) begin
        // Result registers keep the last completed window across a disable.
        state      <= IDLE;
        gate       <= '0;
        per_cnt    <= '0;
        acc_edges  <= '0;
        acc_min    <= '1;
        acc_max    <= '0;
        overflow_q <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise_q) begin
              state     <= MEAS;
              per_cnt   <= '0;
              gate      <= GATE_LOAD;
              acc_edges <= '0;
              acc_min   <= '1;
              acc_max   <= '0;
            end
          end
          MEAS: begin
            per_cnt <= rise_q ? '0 : per_nxt;
            if ((per_cnt == PER_MAX) || edge_sat) overflow_q <= 1'b1;
            if (gate == '0) begin
              // A rise on the closing cycle belongs to the window being reported.
              edge_cnt_q   <= edges_nxt;
              per_min_q    <= min_nxt;
              per_max_q    <= max_nxt;
              meas_valid_q <= 1'b1;
              acc_edges    <= '0;
              acc_min      <= '1;
              acc_max      <= '0;
              gate         <= GATE_LOAD;
            end else begin
              acc_edges <= edges_nxt;
              acc_min   <= min_nxt;
              acc_max   <= max_nxt;
              gate      <= gate - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rise_pulse = rise_q;
  assign bus.edge_cnt   = edge_cnt_q;
  assign bus.per_min    = per_min_q;
  assign bus.per_max    = per_max_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench: wide-period meter (PER_W=12) plus a narrow-period instance (PER_W=4) for saturation.
module tb_clk_freq_meter;
  import clk_meas_pkg::*;

  localparam int GATE = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_freq_meter_if #(.CNT_W(16), .PER_W(12)) bus ();
  clk_freq_meter_if #(.CNT_W(16), .PER_W(4))  bus2 ();

  clk_freq_meter #(.SYNC_STAGES(2), .GATE_CYCLES(GATE), .CNT_W(16), .PER_W(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  clk_freq_meter #(.SYNC_STAGES(2), .GATE_CYCLES(GATE), .CNT_W(16), .PER_W(4)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int pat_k  = 0;
  int sq_k   = 0;
  bit pat_on = 1'b0;
  bit sq_on  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are read 1 time unit after the edge, then inputs for the next edge are set.
  task automatic step();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    if (pat_on) begin
      k = pat_k % 500;
      bus.sig_in = (k < 83) || (k >= 166 && k < 250) || (k >= 333 && k < 416);
      pat_k++;
    end
    if (sq_on) begin
      bus2.sig_in = (sq_k % 40) < 20;
      sq_k++;
    end
  endtask

  task automatic wait_mv(input bit sel, input int bound, input string tag);
    int   n;
    logic v;
    n = 0;
    do begin
      step();
      n++;
      v = sel ? bus2.meas_valid : bus.meas_valid;
    end while (v !== 1'b1 && n < bound);
    check({tag, "_arrive"}, 32'(v === 1'b1), 32'd1);
  endtask

  int nmv;
  int nrise;
  int d_cyc;
  int w_cyc;
  int prev_cyc;

  initial begin
    bus.en = 1'b0;  bus.sig_in = 1'b0;
    bus2.en = 1'b0; bus2.sig_in = 1'b0;

    #12;
    check("rst_edge_cnt", bus.edge_cnt, 0);
    check("rst_per_min", bus.per_min, 12'hFFF);
    check("rst_per_max", bus.per_max, 0);
    check("rst_mv", bus.meas_valid, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_rise", bus.rise_pulse, 0);
    check("rst_per_min_w4", bus2.per_min, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle input: enabled but no edges -> stays armed, never reports
    bus.en = 1'b1;
    nmv = 0; nrise = 0;
    repeat (200) begin
      step();
      nmv += int'(bus.meas_valid);
      nrise += int'(bus.rise_pulse);
    end
    check("idle_no_mv", nmv, 0);
    check("idle_no_rise", nrise, 0);
    check("idle_state_arm", 32'(dut.state), 32'(ARM));

    // Single edge: rise_pulse three clocks later, one cycle wide
    bus.sig_in = 1'b1;
    d_cyc = cyc;
    step(); check("rp_d1", bus.rise_pulse, 0);
    step(); check("rp_d2", bus.rise_pulse, 0);
    step(); check("rp_d3", bus.rise_pulse, 1);
    step(); check("rp_d4", bus.rise_pulse, 0);

    // Empty window after arming edge: reported GATE+4 clocks after the input edge
    wait_mv(1'b0, 1100, "empty");
    check("empty_delay", cyc - d_cyc, 1004);
    check("empty_edge_cnt", bus.edge_cnt, 0);
    check("empty_per_min", bus.per_min, 12'hFFF);
    check("empty_per_max", bus.per_max, 0);
    w_cyc = cyc;
    step();
    check("mv_width", bus.meas_valid, 0);
    bus.sig_in = 1'b0;

    // Boundary edge: edges at W+500 (period 1500) and on the closing cycle W+1000 (period 500)
    repeat (495) step();
    bus.sig_in = 1'b1;
    repeat (204) step();
    bus.sig_in = 1'b0;
    repeat (296) step();
    bus.sig_in = 1'b1;
    repeat (3) step();
    check("bnd_mv_early", bus.meas_valid, 0);
    step();
    check("bnd_cyc", cyc - w_cyc, 1000);
    check("bnd_mv", bus.meas_valid, 1);
    check("bnd_edge_cnt", bus.edge_cnt, 2);
    check("bnd_per_min", bus.per_min, 500);
    check("bnd_per_max", bus.per_max, 1500);
    // Next window's only period is measured from the boundary edge
    repeat (50) step();
    bus.sig_in = 1'b0;
    repeat (46) step();
    bus.sig_in = 1'b1;
    repeat (904) step();
    check("nxt_mv", bus.meas_valid, 1);
    check("nxt_edge_cnt", bus.edge_cnt, 1);
    check("nxt_per_min", bus.per_min, 100);
    check("nxt_per_max", bus.per_max, 100);

    // Disable: back to IDLE, results held
    bus.en = 1'b0;
    bus.sig_in = 1'b0;
    step();
    check("dis_state", 32'(dut.state), 32'(IDLE));
    check("dis_hold_cnt", bus.edge_cnt, 1);
    check("dis_hold_min", bus.per_min, 100);
    step();

    // Clock model: rises spaced 166/167/167
    bus.en = 1'b1;
    pat_k = 0;
    pat_on = 1'b1;
    wait_mv(1'b0, 2000, "cm_w0");
    check("cm_w0_cnt", bus.edge_cnt, 6);
    check("cm_w0_min", bus.per_min, 166);
    check("cm_w0_max", bus.per_max, 167);
    check("cm_w0_ovf", bus.overflow, 0);
    prev_cyc = cyc;
    for (int w = 1; w <= 2; w++) begin
      wait_mv(1'b0, 1100, "cm_wn");
      check("cm_spacing", cyc - prev_cyc, GATE);
      check("cm_cnt", bus.edge_cnt, 6);
      check("cm_min", bus.per_min, 166);
      check("cm_max", bus.per_max, 167);
      prev_cyc = cyc;
    end

    // Asynchronous reset mid-window
    repeat (300) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_edge_cnt", bus.edge_cnt, 0);
    check("arst_per_min", bus.per_min, 12'hFFF);
    check("arst_per_max", bus.per_max, 0);
    check("arst_mv", bus.meas_valid, 0);
    check("arst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    nmv = 0;
    repeat (GATE) begin
      step();
      nmv += int'(bus.meas_valid);
    end
    check("arst_no_mv", nmv, 0);
    wait_mv(1'b0, 1200, "arst_w");
    check("arst_w_cnt", bus.edge_cnt, 6);
    check("arst_w_min", bus.per_min, 166);
    check("arst_w_max", bus.per_max, 167);
    pat_on = 1'b0;
    bus.en = 1'b0;

    // Saturation on the 4-bit period instance: period 40 clamps to 15
    bus2.en = 1'b1;
    sq_k = 0;
    sq_on = 1'b1;
    repeat (200) step();
    check("sat_ovf_set", bus2.overflow, 1);
    wait_mv(1'b1, 1200, "sat_w");
    check("sat_cnt", bus2.edge_cnt, 25);
    check("sat_min", bus2.per_min, 15);
    check("sat_max", bus2.per_max, 15);
    check("sat_ovf_sticky", bus2.overflow, 1);
    bus2.en = 1'b0;
    step();
    check("sat_ovf_clr", bus2.overflow, 0);
    check("sat_state", 32'(dut2.state), 32'(IDLE));
    check("sat_hold_min", bus2.per_min, 15);
    sq_on = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
